mainfsm: RTL and testbench
==========================

Name: mainfsm

Overview:
- Multicycle RISC-V main control FSM.
- Sequences the shared datapath (PC, instruction register, single memory port, register file, ALU) through Fetch/Decode/Execute/Writeback steps.
- Generates the 2-bit ALUOp consumed by aludec, plus all mux selects and write strobes.
- Supports lw, sw, R-type, I-type ALU, jal, beq. Memory accesses are stallable via a ready input.

Parameters:
- none

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- op  input  7  opcode field of the instruction register
- MemReady  input  1  memory access completes this cycle
- PCUpdate  output  1  PC write strobe
- Branch  output  1  conditional PC write (datapath ANDs with Zero)
- IRWrite  output  1  instruction register write strobe
- RegWrite  output  1  register file write strobe
- MemWrite  output  1  data memory write strobe
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 data
- ALUSrcB  output  2  ALU B select: 00 = rs2 data, 01 = ImmExt, 10 = constant 4
- ResultSrc  output  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUOp  output  2  to aludec: 00 = add, 01 = subtract/branch, 10 = funct-decoded
- Illegal  output  1  one-cycle pulse: unsupported opcode seen in Decode
- State  output  4  current state encoding (debug/verification)

Behaviour:
State register
- 4 bits, updated on rising clk.
- reset==0 at an edge sets state to FETCH, regardless of the current state (includes reset mid-instruction).
- While reset==0, IRWrite, PCUpdate, RegWrite, MemWrite, Branch and Illegal are forced to 0.

Outputs
- Combinational decode of state; listed signals only, all others 0.
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10. Values 11–15 are unused and go to FETCH on the next edge, with all outputs 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=MemReady.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; Illegal=1 if op is unsupported.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=MemReady.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- Reset-state outputs are the FETCH values, with strobes 0.

Transitions
- FETCH -> DECODE when MemReady=1; otherwise hold, with strobes 0.
- DECODE by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - anything else -> FETCH, with Illegal pulse
- MEMADR: op 0000011 -> MEMREAD; op 0100011 -> MEMWRITE; else FETCH.
- MEMREAD -> MEMWB when MemReady=1; else hold.
- MEMWRITE -> FETCH when MemReady=1; else hold. MemWrite is asserted only in the completing cycle.
- MEMWB -> FETCH; ALUWB -> FETCH; BEQ -> FETCH.
- EXECUTER, EXECUTEI, JAL -> ALUWB.
- op is sampled every cycle. The datapath holds the IR stable after FETCH, so a mid-instruction op change is not a supported case. The FSM uses the current op in DECODE and MEMADR only.

Latency with MemReady tied 1 (cycles from FETCH to return to FETCH)
- lw = 5
- sw = 4
- R/I-type = 4
- jal = 4
- beq = 3
- illegal = 2
- Each stall cycle adds 1.

Test Plan:
- Reset: reset=0 for 2 edges from state MEMWRITE with MemReady=1 -> State=0, MemWrite=0 during reset; after release, IRWrite=1, ALUSrcB=10, ResultSrc=10.
- lw, op=0000011, MemReady=1 -> State sequence 0,1,2,3,4,0. RegWrite=1 only in state 4, with ResultSrc=01. AdrSrc=1 in state 3.
- sw with MemReady low 3 cycles in MEMWRITE -> State stays 5 for 3 cycles with MemWrite=0. MemWrite=1 for exactly the one cycle MemReady=1, then State=0.
- R-type op=0110011 then beq op=1100011 -> ALUOp=10 in state 6; ALUOp=01 and Branch=1 in state 10; sequences 0,1,6,7,0 and 0,1,10,0.
- jal op=1101111 -> state 9 shows PCUpdate=1, ALUSrcA=01, ALUSrcB=10; then state 7 with RegWrite=1.
- Illegal op=1111111 in DECODE -> Illegal=1 for exactly one cycle, next State=0, no RegWrite/MemWrite. Fetch stall with MemReady=0 for 4 cycles -> IRWrite=0, PCUpdate=0 held in state 0.

Source files
------------

// File: rtl/mainfsm.sv
// Multicycle RISC-V main control FSM: steps the shared datapath through
// fetch/decode/execute/writeback and drives every select and write strobe.
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       MemReady,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    state <= MemReady ? DECODE : FETCH;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXECUTER;
            OP_I:         state <= EXECUTEI;
            OP_JAL:       state <= JAL;
            OP_BEQ:       state <= BEQ;
            default:      state <= FETCH;
          endcase
        end
        MEMADR: begin
          if (op == OP_LW)      state <= MEMREAD;
          else if (op == OP_SW) state <= MEMWRITE;
          else                  state <= FETCH;
        end
        MEMREAD:  state <= MemReady ? MEMWB : MEMREAD;
        MEMWRITE: state <= MemReady ? FETCH : MEMWRITE;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        JAL:      state <= ALUWB;
        default:  state <= FETCH;
      endcase
    end
  end

  // Strobes are qualified by reset combinationally so nothing is written
  // during the reset cycle even though the state register still holds the
  // pre-reset state on that cycle.
  always_comb begin
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    Illegal   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 2'b00;
    case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady & reset;
        PCUpdate  = MemReady & reset;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: Illegal = 1'b0;
          default:                                  Illegal = reset;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = reset;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = MemReady & reset;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = reset;
      end
      ALUWB:    RegWrite = reset;
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = reset;
      end
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_mainfsm.sv
// Scoreboard bench for mainfsm: stimulus pushes the expected per-cycle state
// and output vector, a negedge monitor pops and compares.
module tb_mainfsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       MemReady;
  logic       PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic [3:0] State;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  mainfsm dut (
    .clk(clk), .reset(reset), .op(op), .MemReady(MemReady),
    .PCUpdate(PCUpdate), .Branch(Branch), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUOp(ALUOp), .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  // {State, PCUpdate, Branch, IRWrite, RegWrite, MemWrite, Illegal,
  //  AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp}
  logic [18:0] exp_q[$];
  string       name_q[$];
  int tests  = 0;
  int errors = 0;

  function automatic logic [18:0] expect_vec(input logic [3:0] st, input logic rst,
                                             input logic [6:0] opc, input logic mr);
    logic pcu, br, irw, rw, mw, ill, adr;
    logic [1:0] sa, sb, rs, ao;
    {pcu, br, irw, rw, mw, ill, adr} = '0;
    {sa, sb, rs, ao} = '0;
    case (st)
      4'd0:  begin sb = 2'b10; rs = 2'b10; irw = mr & rst; pcu = mr & rst; end
      4'd1:  begin sa = 2'b01; sb = 2'b01;
               ill = rst & !(opc inside {LW, SW, RT, IT, JL, BQ}); end
      4'd2:  begin sa = 2'b10; sb = 2'b01; end
      4'd3:  adr = 1'b1;
      4'd4:  begin rs = 2'b01; rw = rst; end
      4'd5:  begin adr = 1'b1; mw = mr & rst; end
      4'd6:  begin sa = 2'b10; ao = 2'b10; end
      4'd7:  rw = rst;
      4'd8:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      4'd9:  begin sa = 2'b01; sb = 2'b10; pcu = rst; end
      4'd10: begin sa = 2'b10; ao = 2'b01; br = rst; end
      default: ;
    endcase
    return {st, pcu, br, irw, rw, mw, ill, adr, sa, sb, rs, ao};
  endfunction

  // Drive one cycle's inputs and queue the response expected for that cycle.
  task automatic step(input string nm, input logic rst, input logic [6:0] opc,
                      input logic mr, input logic [3:0] st);
    reset    = rst;
    op       = opc;
    MemReady = mr;
    exp_q.push_back(expect_vec(st, rst, opc, mr));
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [18:0] got, want;
      string nm;
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      got  = {State, PCUpdate, Branch, IRWrite, RegWrite, MemWrite, Illegal,
              AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp};
      tests++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                 nm, got[18:15], got[14:0], want[18:15], want[14:0]);
      end
    end
  end

  initial begin
    reset = 1'b0; op = '0; MemReady = 1'b0;
    @(posedge clk); #1;
    step("reset_hold", 1'b0, 7'd0, 1'b1, 4'd0);

    // lw: 0,1,2,3,4
    step("lw_fetch",   1'b1, LW, 1'b1, 4'd0);
    step("lw_decode",  1'b1, LW, 1'b1, 4'd1);
    step("lw_memadr",  1'b1, LW, 1'b1, 4'd2);
    step("lw_memread", 1'b1, LW, 1'b1, 4'd3);
    step("lw_memwb",   1'b1, LW, 1'b1, 4'd4);

    // sw with three stall cycles in MEMWRITE
    step("sw_fetch",   1'b1, SW, 1'b1, 4'd0);
    step("sw_decode",  1'b1, SW, 1'b1, 4'd1);
    step("sw_memadr",  1'b1, SW, 1'b1, 4'd2);
    for (int i = 0; i < 3; i++) step("sw_stall", 1'b1, SW, 1'b0, 4'd5);
    step("sw_complete", 1'b1, SW, 1'b1, 4'd5);

    // R-type then beq
    step("r_fetch",  1'b1, RT, 1'b1, 4'd0);
    step("r_decode", 1'b1, RT, 1'b1, 4'd1);
    step("r_exec",   1'b1, RT, 1'b1, 4'd6);
    step("r_aluwb",  1'b1, RT, 1'b1, 4'd7);
    step("beq_fetch",  1'b1, BQ, 1'b1, 4'd0);
    step("beq_decode", 1'b1, BQ, 1'b1, 4'd1);
    step("beq_branch", 1'b1, BQ, 1'b1, 4'd10);

    // jal
    step("jal_fetch",  1'b1, JL, 1'b1, 4'd0);
    step("jal_decode", 1'b1, JL, 1'b1, 4'd1);
    step("jal_jump",   1'b1, JL, 1'b1, 4'd9);
    step("jal_aluwb",  1'b1, JL, 1'b1, 4'd7);

    // illegal opcode, then a fetch stall
    step("ill_fetch",  1'b1, BAD, 1'b1, 4'd0);
    step("ill_decode", 1'b1, BAD, 1'b1, 4'd1);
    for (int i = 0; i < 4; i++) step("fetch_stall", 1'b1, BAD, 1'b0, 4'd0);

    // I-type
    step("i_fetch",  1'b1, IT, 1'b1, 4'd0);
    step("i_decode", 1'b1, IT, 1'b1, 4'd1);
    step("i_exec",   1'b1, IT, 1'b1, 4'd8);
    step("i_aluwb",  1'b1, IT, 1'b1, 4'd7);

    // reset taken from MEMWRITE with MemReady high
    step("rs_fetch",  1'b1, SW, 1'b1, 4'd0);
    step("rs_decode", 1'b1, SW, 1'b1, 4'd1);
    step("rs_memadr", 1'b1, SW, 1'b1, 4'd2);
    step("rs_in_memwrite", 1'b0, SW, 1'b1, 4'd5);
    step("rs_second",      1'b0, SW, 1'b1, 4'd0);
    step("rs_release",     1'b1, SW, 1'b1, 4'd0);
    step("rs_after",       1'b1, SW, 1'b1, 4'd1);

    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
